// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI arbiter.
//   state_t    - arbiter FSM states
//   op_t       - operand bundle latched from the granted requester
//   ADDR_LIMIT - first address rejected when SPI_ARB_ADDR_CHECK_EN is defined
package spi_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
  } op_t;

  localparam int ADDR_LIMIT = 32;

  function automatic logic addr_bad(input logic [7:0] a);
    return int'(a) >= ADDR_LIMIT;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req - request vector
//   ptr - highest-priority index; search ascends from here, wrapping mod NREQ
//   sel - one-hot winner (all zero when req is zero)
//   idx - binary index of the winner
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         sel,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int PW = $clog2(NREQ);

  int            jt;
  logic [PW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest requester after
  // ptr is the last one written and therefore wins.
  always_comb begin
    sel = '0;
    idx = '0;
    jt  = 0;
    j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      jt = int'(ptr) + k;
      if (jt >= NREQ) jt = jt - NREQ;
      j = jt[PW-1:0];
      if (req[j]) begin
        sel    = '0;
        sel[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI controller among NREQ
// requesters, one transaction outstanding at a time.
//   clk, rst          - clock, asynchronous active-low reset
//   req/req_wr/
//   req_addr/req_din  - per-requester request and operands (8-bit slices)
//   gnt, ack          - one-hot one-cycle accept / complete pulses
//   rsp_dout, rsp_err - response, valid while ack is high
//   busy              - high whenever the FSM is not idle
//   m_rst             - synchronous reset to the controller (1 = parked)
//   m_wr/m_addr/m_din - operands to the controller
//   m_done/m_err/
//   m_dout            - controller completion, error and read data
// Optional: define SPI_ARB_ADDR_CHECK_EN to reject addr >= ADDR_LIMIT
// without launching the controller.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rsp_dout,
  output logic              rsp_err,
  output logic              busy,
  output logic              m_rst,
  output logic              m_wr,
  output logic [7:0]        m_addr,
  output logic [7:0]        m_din,
  input  logic              m_done,
  input  logic              m_err,
  input  logic [7:0]        m_dout
);

  localparam int            PW      = $clog2(NREQ);
  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] LAST    = PW'(NREQ - 1);

  state_t          state, nstate;
  logic [PW-1:0]   ptr, cur, pick_idx;
  logic [NREQ-1:0] pick_sel;
  op_t             pick_op, op;
  logic [CW-1:0]   cnt;
  logic            pick_bad;
  logic            timed_out;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .sel (pick_sel),
    .idx (pick_idx)
  );

  always_comb begin
    pick_op = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_sel[i]) pick_op = {req_wr[i], req_addr[8*i +: 8], req_din[8*i +: 8]};
  end

`ifdef SPI_ARB_ADDR_CHECK_EN
  assign pick_bad = addr_bad(pick_op.addr);
`else
  assign pick_bad = 1'b0;
`endif

  assign timed_out = (cnt == TMAX);
  assign m_wr      = op.wr;
  assign m_addr    = op.addr;
  assign m_din     = op.din;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  // Next state; m_done has priority over the timeout
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   if (|req) nstate = pick_bad ? S_RESP : S_LAUNCH;
      S_LAUNCH: nstate = S_WAIT;
      S_WAIT:   if (m_done || timed_out) nstate = S_RESP;
      S_RESP:   nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy  = (state != S_IDLE);
    m_rst = (state == S_IDLE) || (state == S_RESP);
  end

  // Datapath. The launch cycle counts as cycle 0 of the wait, so WAIT
  // starts with cnt=1 and its last possible cycle is TIMEOUT cycles after
  // launch. cnt leaves WAIT on reaching TMAX, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      cur      <= '0;
      op       <= '0;
      cnt      <= '0;
      gnt      <= '0;
      ack      <= '0;
      rsp_dout <= '0;
      rsp_err  <= 1'b0;
    end else begin
      gnt <= '0;
      ack <= '0;
      case (state)
        S_IDLE: if (|req) begin
          cur <= pick_idx;
          op  <= pick_op;
          gnt <= pick_sel;
          cnt <= '0;
          if (pick_bad) begin
            rsp_err  <= 1'b1;
            rsp_dout <= '0;
          end
        end
        S_LAUNCH: cnt <= CNT_ONE;
        S_WAIT: begin
          if (m_done) begin
            rsp_dout <= m_dout;
            rsp_err  <= m_err;
          end else if (timed_out) begin
            rsp_dout <= '0;
            rsp_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          ack[cur] <= 1'b1;
          ptr      <= (cur == LAST) ? '0 : cur + 1'b1;
          cnt      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, 4, number of requesters (2..8); TIMEOUT, 255, maximum cycles to wait for m_done.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  NREQ  per-requester transaction request.
REQ-005 req_wr  input  NREQ  per-requester 1=write, 0=read.
REQ-006 req_addr  input  8*NREQ  per-requester address; slice i is [8i+7:8i].
REQ-007 req_din  input  8*NREQ  per-requester write data.
REQ-008 gnt  output  NREQ  one-hot, one-cycle pulse when a request is accepted.
REQ-009 ack  output  NREQ  one-hot, one-cycle pulse when a transaction completes.
REQ-010 rsp_dout  output  8  read data, valid while ack is asserted.
REQ-011 rsp_err  output  1  error flag, valid while ack is asserted.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 m_rst  output  1  active-high synchronous reset to the SPI controller; holds it parked.
REQ-014 m_wr, m_addr, m_din  output  1/8/8  operands to the SPI controller, stable while m_rst=0.
REQ-015 m_done, m_err  input  1/1  SPI controller completion and error flags.
REQ-016 m_dout  input  8  SPI controller read data.

Function
REQ-017 The FSM SHALL have the states IDLE, LAUNCH, WAIT and RESP.
REQ-018 IDLE, with any req bit high: pick index i by round-robin starting at ptr (ascending, mod NREQ), latch req_wr[i]/req_addr[i]/req_din[i] into m_wr/m_addr/m_din, pulse gnt[i] next cycle, go to LAUNCH.
REQ-019 req SHALL be sampled only in IDLE; requesters hold operands until gnt and MAY withdraw before gnt.
REQ-020 LAUNCH: drive m_rst=0, clear the timeout counter, go to WAIT after exactly one cycle.
REQ-021 WAIT: keep m_rst=0 and increment the counter.
- On m_done=1: capture m_dout into rsp_dout and m_err into rsp_err, go to RESP.
- If m_done and counter==TIMEOUT occur in the same cycle, m_done wins.
REQ-022 WAIT timeout: when the counter reaches TIMEOUT without m_done, set rsp_err=1 and rsp_dout=0x00, go to RESP.
REQ-023 RESP: drive m_rst=1, pulse ack[i] for one cycle, set ptr=(i+1) mod NREQ, return to IDLE.
REQ-024 m_rst SHALL be 1 in IDLE and RESP, and 0 in LAUNCH and WAIT.
REQ-025 On a write, rsp_dout SHALL equal the last captured m_dout; requesters ignore it.
REQ-026 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL NOT wrap.
REQ-027 Minimum grant-to-ack latency SHALL be 3 cycles; at most one transaction is outstanding.

Reset
REQ-028 On rst=0, independent of clk:
- state=IDLE, ptr=0, gnt=0, ack=0, rsp_dout=0, rsp_err=0, busy=0;
- m_rst=1, m_wr=0, m_addr=0, m_din=0, counter=0.
REQ-029 A reset asserted mid-transaction SHALL abort it with no ack issued; the requester re-requests.

Configuration
REQ-030 With SPI_ARB_ADDR_CHECK_EN defined:
- an accepted request with addr>=32 SHALL go straight from IDLE to RESP, keeping m_rst=1;
- it SHALL return ack with rsp_err=1, one cycle after gnt.
REQ-031 Without SPI_ARB_ADDR_CHECK_EN: every request is launched, and address errors come only from m_err.

Structure
REQ-032 Package spi_arb_pkg SHALL hold the state enum and the constant ADDR_LIMIT=32.
REQ-033 Sub-module rr_pick SHALL hold the combinational round-robin picker: inputs req and ptr, outputs a one-hot select and its index.

Verification
REQ-034 Single read: req[1]=1, wr=0, addr=0x05; model returns m_dout=0xA5 with m_done after 20 cycles -> gnt[1], then ack[1] with rsp_dout=0xA5, rsp_err=0.
REQ-035 Contention: req=4'b1111 with ptr=0 -> grants in order 0,1,2,3; then req=4'b0011 -> next grant is 0.
REQ-036 Timeout: model never asserts m_done, TIMEOUT=255 -> ack with rsp_err=1 and rsp_dout=0x00, 257 cycles after gnt; m_rst returns to 1.
REQ-037 Address error: addr=0x40 -> with the macro defined, ack with rsp_err=1 one cycle after gnt and m_rst stays 1; without it, m_err=1 is passed through.
REQ-038 Reset in WAIT: rst=0 for 2 cycles -> no ack; all outputs at reset values; ptr=0.
REQ-039 Simultaneous events: m_done and counter==TIMEOUT in the same cycle -> rsp_err equals m_err.
